// File: rtl/neural_nexus_core.sv
// neural_nexus_core: two-stage temporal blend of current/next frame pixels.
// pixel_out = round((pixel_t*w_t + pixel_t1*w_t1) / 256), w_t from mask with
// mask 255 promoted to 256 so both endpoints pass a pixel through exactly.
module neural_nexus_core #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,      // active-high synchronous reset
   input  logic [DATA_W-1:0] pixel_t,
   input  logic [DATA_W-1:0] pixel_t1,
   input  logic [DATA_W-1:0] mask,
   output logic [DATA_W-1:0] pixel_out
);

   localparam int W_W    = DATA_W + 1;          // weight width (0..256)
   localparam int PROD_W = DATA_W + W_W;        // product width
   localparam logic [W_W-1:0]    W_FULL  = W_W'(1 << DATA_W);
   localparam logic [PROD_W-1:0] ROUND_C = PROD_W'(1 << (DATA_W - 1));

   logic [W_W-1:0]    w_wt;
   logic [W_W-1:0]    w_wt1;
   logic [PROD_W-1:0] w_prod_t;
   logic [PROD_W-1:0] w_prod_t1;
   logic [PROD_W-1:0] w_sum;
   logic [DATA_W-1:0] w_blend;

   logic [PROD_W-1:0] r_prod_t;
   logic [PROD_W-1:0] r_prod_t1;

   assign w_wt      = (mask == {DATA_W{1'b1}}) ? W_FULL : {1'b0, mask};
   assign w_wt1     = W_FULL - w_wt;
   assign w_prod_t  = PROD_W'(pixel_t)  * PROD_W'(w_wt);
   assign w_prod_t1 = PROD_W'(pixel_t1) * PROD_W'(w_wt1);

   assign w_sum = r_prod_t + r_prod_t1 + ROUND_C;

   // Sum cannot reach bit PROD_W-1 with in-range weights; clamp kept as a guard.
   assign w_blend = w_sum[PROD_W-1] ? {DATA_W{1'b1}} : w_sum[2*DATA_W-1:DATA_W];

   // Stage 1: register both weighted products; reset flushes in-flight samples.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_prod_t  <= '0;
         r_prod_t1 <= '0;
      end else begin
         r_prod_t  <= w_prod_t;
         r_prod_t1 <= w_prod_t1;
      end
   end

   // Stage 2: round, scale down and register the output pixel.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         pixel_out <= '0;
      end else begin
         pixel_out <= w_blend;
      end
   end

endmodule

// File: tb/tb_neural_nexus_core.sv
// Self-checking bench for neural_nexus_core: directed endpoint/stream cases,
// reset behaviour and a random sweep against a latency-aware reference model.
module tb_neural_nexus_core;

   logic       clk;
   logic       rst_n;
   logic [7:0] pixel_t;
   logic [7:0] pixel_t1;
   logic [7:0] mask;
   logic [7:0] pixel_out;

   int n_chk;
   int n_fail;

   // reference model: value expected in the middle of the pipe and at the output
   int m_mid;
   int m_out;

   neural_nexus_core #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pixel_t   (pixel_t),
      .pixel_t1  (pixel_t1),
      .mask      (mask),
      .pixel_out (pixel_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int blend(int pt, int p1, int m);
      int wt;
      int r;
      wt = (m == 255) ? 256 : m;
      r  = (pt * wt + p1 * (256 - wt) + 128) / 256;
      if (r > 255) r = 255;
      return r;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: pixel_out=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // one clock: drive inputs, advance model at the edge, compare on falling edge
   task automatic step(input int pt, input int p1, input int m, input bit rst, input string tag);
      pixel_t  = 8'(pt);
      pixel_t1 = 8'(p1);
      mask     = 8'(m);
      rst_n    = rst;
      @(posedge clk);
      if (rst) begin
         m_out = 0;
         m_mid = 0;
      end else begin
         m_out = m_mid;
         m_mid = blend(pt, p1, m);
      end
      @(negedge clk);
      check(tag, pixel_out, 8'(m_out));
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      m_mid    = 0;
      m_out    = 0;
      rst_n    = 1'b1;
      pixel_t  = '0;
      pixel_t1 = '0;
      mask     = '0;

      // reset held for two edges with random inputs
      for (int i = 0; i < 2; i++) begin
         step($urandom_range(255), $urandom_range(255), $urandom_range(255), 1'b1, "rst_model");
         check("rst_zero", pixel_out, 8'd0);
      end

      // back-to-back directed stream straight after release
      step(100, 200, 0,   1'b0, "s0");
      check("pipe_zero", pixel_out, 8'd0);
      step(100, 200, 255, 1'b0, "s1");
      check("mask0", pixel_out, 8'd200);
      step(100, 200, 128, 1'b0, "s2");
      check("mask255", pixel_out, 8'd100);
      step(255, 0,   255, 1'b0, "s3");
      check("mask128", pixel_out, 8'd150);
      step(0,   255, 64,  1'b0, "s4");
      check("mask255_max", pixel_out, 8'd255);
      step(0,   0,   0,   1'b0, "s5");
      check("mask64", pixel_out, 8'd191);
      step(0,   0,   0,   1'b0, "s6");
      check("zero_px", pixel_out, 8'd0);

      // random sweep with a single-cycle reset mid-stream
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) begin
            step($urandom_range(255), $urandom_range(255), $urandom_range(255), 1'b1, "mid_rst");
            check("mid_rst_zero", pixel_out, 8'd0);
            step($urandom_range(255), $urandom_range(255), $urandom_range(255), 1'b0, "mid_flush");
            check("mid_flush_zero", pixel_out, 8'd0);
         end else begin
            step($urandom_range(255), $urandom_range(255), $urandom_range(255), 1'b0, "rand");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
